// File: rtl/configuration_registers_tx.sv
// Device-to-host register word serializer: captures one address/data word and
// emits it as TX_DATA_WIDTH-bit bytes (address MSB-first, then data LSB-first).
module configuration_registers_tx #(
  parameter int TX_DATA_WIDTH  = 8,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  output logic                      register_ack,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  input  logic                      tx_ack,
  output logic                      busy
);

  localparam int NA    = REG_ADDR_WIDTH / TX_DATA_WIDTH;
  localparam int ND    = REG_DATA_WIDTH / TX_DATA_WIDTH;
  localparam int MAXN  = (NA > ND) ? NA : ND;
  localparam int CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [CNT_W-1:0] NA_LAST = CNT_W'(NA - 1);
  localparam logic [CNT_W-1:0] ND_LAST = CNT_W'(ND - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ADDR = 2'd1,
    SEND_DATA = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0]  addr_sr_q, addr_sr_d;
  logic [REG_DATA_WIDTH-1:0]  data_sr_q, data_sr_d;
  logic [TX_DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                       tx_rdy_q, tx_rdy_d;
  logic                       busy_q, busy_d;
  logic                       register_ack_q, register_ack_d;
  logic                       ack_ok;

  // An ack only counts while a byte is actually being presented.
  assign ack_ok = tx_ack && tx_rdy_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_sr_d      = addr_sr_q;
    data_sr_d      = data_sr_q;
    tx_data_d      = tx_data_q;
    tx_rdy_d       = tx_rdy_q;
    busy_d         = busy_q;
    register_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (register_rdy) begin
          register_ack_d = 1'b1;
          state_d        = SEND_ADDR;
          cnt_d          = '0;
          // First address byte goes straight to the output; the shift
          // register keeps the remaining bytes aligned at the top.
          tx_data_d      = register_addr[REG_ADDR_WIDTH-1 -: TX_DATA_WIDTH];
          addr_sr_d      = register_addr << TX_DATA_WIDTH;
          data_sr_d      = register_data;
          tx_rdy_d       = 1'b1;
          busy_d         = 1'b1;
        end
      end

      SEND_ADDR: begin
        if (ack_ok) begin
          if (cnt_q == NA_LAST) begin
            state_d   = SEND_DATA;
            cnt_d     = '0;
            tx_data_d = data_sr_q[TX_DATA_WIDTH-1:0];
            data_sr_d = data_sr_q >> TX_DATA_WIDTH;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            tx_data_d = addr_sr_q[REG_ADDR_WIDTH-1 -: TX_DATA_WIDTH];
            addr_sr_d = addr_sr_q << TX_DATA_WIDTH;
          end
        end
      end

      SEND_DATA: begin
        if (ack_ok) begin
          if (cnt_q == ND_LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            tx_rdy_d = 1'b0;
            busy_d   = 1'b0;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            tx_data_d = data_sr_q[TX_DATA_WIDTH-1:0];
            data_sr_d = data_sr_q >> TX_DATA_WIDTH;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        tx_rdy_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tx_data_q      <= '0;
      tx_rdy_q       <= 1'b0;
      busy_q         <= 1'b0;
      register_ack_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_data_q      <= tx_data_d;
      tx_rdy_q       <= tx_rdy_d;
      busy_q         <= busy_d;
      register_ack_q <= register_ack_d;
    end
  end

  // Shift registers carry payload only; they are always reloaded on capture.
  always_ff @(posedge clk) begin
    addr_sr_q <= addr_sr_d;
    data_sr_q <= data_sr_d;
  end

  assign register_ack = register_ack_q;
  assign tx_data      = tx_data_q;
  assign tx_rdy       = tx_rdy_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_configuration_registers_tx.sv
// Directed bench for configuration_registers_tx: vector table of frames plus
// hand sequences for busy rejection, spurious acks, mid-frame reset, wide words.
module tb_configuration_registers_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        register_ack;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_ack;
  logic        busy;

  logic [15:0] w_addr;
  logic [31:0] w_data;
  logic        w_rdy;
  logic        w_ack;
  logic [7:0]  w_tx_data;
  logic        w_tx_rdy;
  logic        w_tx_ack;
  logic        w_busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  configuration_registers_tx #(
    .TX_DATA_WIDTH(8), .REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .register_addr(register_addr), .register_data(register_data),
    .register_rdy(register_rdy), .register_ack(register_ack),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_ack(tx_ack), .busy(busy)
  );

  configuration_registers_tx #(
    .TX_DATA_WIDTH(8), .REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(32)
  ) dut_w (
    .clk(clk), .rst(rst),
    .register_addr(w_addr), .register_data(w_data),
    .register_rdy(w_rdy), .register_ack(w_ack),
    .tx_data(w_tx_data), .tx_rdy(w_tx_rdy), .tx_ack(w_tx_ack), .busy(w_busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    int          dly;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_reg_ack();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (register_ack === 1'b1) break;
    end
    chk("register_ack_seen", {31'd0, register_ack}, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [15:0] d, input int dly,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp_b[3];
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    register_addr = a;
    register_data = d;
    register_rdy  = 1'b1;
    wait_reg_ack();
    register_rdy = 1'b0;
    chk("cap_tx_rdy", {31'd0, tx_rdy}, 32'd1);
    chk("cap_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("byte", {24'd0, tx_data}, {24'd0, exp_b[i]});
      for (int w = 0; w < dly; w++) begin
        @(negedge clk);
        chk("hold_byte", {24'd0, tx_data}, {24'd0, exp_b[i]});
        chk("hold_rdy", {31'd0, tx_rdy}, 32'd1);
      end
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      chk("ack_pulse", {31'd0, register_ack}, 32'd0);
    end
    chk("end_tx_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] wire_b[6];
    logic [7:0] exp6[6];

    vt[0] = '{a: 8'h12, d: 16'hABCD, dly: 1, b0: 8'h12, b1: 8'hCD, b2: 8'hAB};
    vt[1] = '{a: 8'h12, d: 16'hABCD, dly: 5, b0: 8'h12, b1: 8'hCD, b2: 8'hAB};
    vt[2] = '{a: 8'h34, d: 16'h5678, dly: 0, b0: 8'h34, b1: 8'h78, b2: 8'h56};
    vt[3] = '{a: 8'hFF, d: 16'h0000, dly: 2, b0: 8'hFF, b1: 8'h00, b2: 8'h00};
    vt[4] = '{a: 8'h00, d: 16'hFFFF, dly: 1, b0: 8'h00, b1: 8'hFF, b2: 8'hFF};

    rst = 1'b1; register_addr = '0; register_data = '0; register_rdy = 1'b0; tx_ack = 1'b0;
    w_addr = '0; w_data = '0; w_rdy = 1'b0; w_tx_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_register_ack", {31'd0, register_ack}, 32'd0);
    chk("rst_tx_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_frame(vt[v].a, vt[v].d, vt[v].dly, vt[v].b0, vt[v].b1, vt[v].b2);
      @(negedge clk);
    end

    // Busy rejection: B held during A, captured right after A's last ack.
    register_addr = 8'h01; register_data = 16'h1111; register_rdy = 1'b1;
    wait_reg_ack();
    register_addr = 8'h02; register_data = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      wire_b[i] = tx_data;
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      chk("busy_no_ack", {31'd0, register_ack}, 32'd0);
    end
    chk("gap_tx_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("b_captured", {31'd0, register_ack}, 32'd1);
    register_rdy = 1'b0;
    for (int i = 3; i < 6; i++) begin
      wire_b[i] = tx_data;
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
    end
    exp6[0] = 8'h01; exp6[1] = 8'h11; exp6[2] = 8'h11;
    exp6[3] = 8'h02; exp6[4] = 8'h22; exp6[5] = 8'h22;
    for (int i = 0; i < 6; i++) chk("busy_wire", {24'd0, wire_b[i]}, {24'd0, exp6[i]});
    chk("busy_end", {31'd0, busy}, 32'd0);

    // Spurious ack in IDLE, then at frame end.
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("spur_idle_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("spur_idle_busy", {31'd0, busy}, 32'd0);
    chk("spur_idle_ack", {31'd0, register_ack}, 32'd0);
    run_frame(8'h5A, 16'hC3A5, 0, 8'h5A, 8'hA5, 8'hC3);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("spur_end_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("spur_end_busy", {31'd0, busy}, 32'd0);
    chk("spur_end_ack", {31'd0, register_ack}, 32'd0);
    run_frame(8'h12, 16'hABCD, 0, 8'h12, 8'hCD, 8'hAB);

    // Reset after the first byte is acked.
    register_addr = 8'h12; register_data = 16'hABCD; register_rdy = 1'b1;
    wait_reg_ack();
    register_rdy = 1'b0;
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("pre_rst_byte", {24'd0, tx_data}, 32'h0000_00CD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_tx_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    run_frame(8'h34, 16'h5678, 1, 8'h34, 8'h78, 8'h56);

    // Wide variant: 2 address bytes MSB-first, 4 data bytes LSB-first.
    w_addr = 16'hA1B2; w_data = 32'h0102_0304; w_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w_ack === 1'b1) break;
    end
    chk("wide_ack", {31'd0, w_ack}, 32'd1);
    w_rdy = 1'b0;
    exp6[0] = 8'hA1; exp6[1] = 8'hB2; exp6[2] = 8'h04;
    exp6[3] = 8'h03; exp6[4] = 8'h02; exp6[5] = 8'h01;
    for (int i = 0; i < 6; i++) begin
      chk("wide_rdy", {31'd0, w_tx_rdy}, 32'd1);
      chk("wide_byte", {24'd0, w_tx_data}, {24'd0, exp6[i]});
      w_tx_ack = 1'b1;
      @(negedge clk);
      w_tx_ack = 1'b0;
    end
    chk("wide_end_rdy", {31'd0, w_tx_rdy}, 32'd0);
    chk("wide_end_busy", {31'd0, w_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
